// File: rtl/gmii_rx_frame_checker.sv
// gmii_rx_frame_checker
//   Receive-side GMII framer. Finds frames on gmii_rx_dv, strips the
//   preamble/SFD and the 4-byte FCS, and checks CRC-32, length and
//   gmii_rx_er. The payload leaves as a non-stallable byte stream, and
//   the last beat of each frame carries the frame status.
//
// Ports
//   clock, reset_n        GMII RX clock; async-assert, active-low reset
//   gmii_rxd/_dv/_er      GMII receive bus from the PCS/PMA
//   m_data, m_valid       payload beat (no back-pressure)
//   m_last, m_err         final beat of frame / frame is bad (only with m_last)
//   good_count, bad_count saturating 16-bit frame counters
//   dbg_state             current FSM state (see state_t encoding)
//
// Stream handshake: m_valid is a one-cycle qualifier with no ready. A beat
// is transferred on every cycle that m_valid=1. m_data holds its previous
// value while m_valid=0. m_last and m_err are forced to 0 while m_valid=0.
module gmii_rx_frame_checker #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        m_err,
    output logic [15:0] good_count,
    output logic [15:0] bad_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    localparam int               LEN_W   = $clog2(MAX_FRAME + 2);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME + 1);
    localparam logic [LEN_W-1:0] LEN_FCS = LEN_W'(5);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [7:0]  SYM_PRE     = 8'h55;
    localparam logic [7:0]  SYM_SFD     = 8'hD5;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  d);
        logic [31:0] c;
        c = crc_in;
        for (int k = 0; k < 8; k++) begin
            c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ d[k]}});
        end
        return c;
    endfunction

    state_t           state_q, state_d;
    logic             armed_q;
    logic [31:0]      crc_q;
    logic [LEN_W-1:0] len_q;
    logic             sticky_er_q;
    logic [7:0]       sb_q [0:4];   // sb_q[0] newest, sb_q[4] is P_(i-5)

    logic             capture;
    logic             frame_end;
    logic             is_runt;
    logic             frame_bad;

    assign dbg_state = state_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state and control strobes ----------------
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Until dv has been seen low once since reset, we may be in
                // the middle of someone else's frame; do not resync there.
                if (gmii_rx_dv && armed_q) begin
                    if (gmii_rxd == SYM_PRE)      state_d = S_PREAMBLE;
                    else if (gmii_rxd == SYM_SFD) state_d = S_PAYLOAD;
                    else                          state_d = S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!gmii_rx_dv)                  state_d = S_IDLE;
                else if (gmii_rxd == SYM_SFD)     state_d = S_PAYLOAD;
                else if (gmii_rxd != SYM_PRE)     state_d = S_DROP;
            end
            S_PAYLOAD: begin
                if (gmii_rx_dv) begin
                    capture = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DROP: begin
                if (!gmii_rx_dv)                  state_d = S_IDLE;
            end
            default:                              state_d = S_IDLE;
        endcase
    end

    // A runt of 4 bytes or fewer has no payload to emit behind the FCS hold-back.
    assign is_runt   = (len_q < LEN_FCS);
    assign frame_bad = sticky_er_q || is_runt || (len_q < LEN_MIN) ||
                       (len_q > LEN_MAX) || (crc_q != CRC_RESIDUE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
        end else if (!gmii_rx_dv) begin
            armed_q <= 1'b1;
        end
    end

    // ---------------- datapath, output stream and counters ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            sticky_er_q <= 1'b0;
            for (int i = 0; i < 5; i++) sb_q[i] <= 8'h00;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_err       <= 1'b0;
            good_count  <= 16'h0000;
            bad_count   <= 16'h0000;
        end else begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;

            if (capture) begin
                crc_q       <= crc_byte(crc_q, gmii_rxd);
                sb_q[0]     <= gmii_rxd;
                for (int i = 1; i < 5; i++) sb_q[i] <= sb_q[i-1];
                len_q       <= (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
                sticky_er_q <= sticky_er_q | gmii_rx_er;
                // Four bytes are always held back: they might be the FCS.
                if (len_q >= LEN_FCS) begin
                    m_valid <= 1'b1;
                    m_data  <= sb_q[4];
                end
            end

            if (frame_end) begin
                m_valid <= 1'b1;
                m_last  <= 1'b1;
                m_data  <= is_runt ? 8'h00 : sb_q[4];
                m_err   <= frame_bad;
                if (frame_bad) begin
                    if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
                end else begin
                    if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
                end
                len_q       <= '0;
                crc_q       <= CRC_INIT;
                sticky_er_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Directed bench for gmii_rx_frame_checker. A driver sends GMII frames,
// expected payload beats go into exp_q, and a negedge monitor compares every
// output beat and idle cycle against that queue.
module tb_gmii_rx_frame_checker;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_err;
    logic [15:0] good_count, bad_count;
    logic [1:0]  dbg_state;

    always #4 clock = ~clock;

    gmii_rx_frame_checker #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_err      (m_err),
        .good_count (good_count),
        .bad_count  (bad_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  exp_q[$];          // {last, err, data}
    logic [7:0]  frm[$];            // frame body after SFD, FCS included
    logic [15:0] exp_good = 16'd0;
    logic [15:0] exp_bad  = 16'd0;
    logic        in_frame = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        logic [9:0] beat;
        if (!reset_n) begin
            in_frame  = 1'b0;
            hold_data = 8'h00;
        end else begin
            if (in_frame) begin
                check("contiguous_beat", 32'(m_valid), 32'd1);
                if (!m_valid) in_frame = 1'b0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(m_valid), 32'd0);
                    in_frame = 1'b0;
                end else begin
                    beat = exp_q.pop_front();
                    check("beat_last_err_data", 32'({m_last, m_err, m_data}), 32'(beat));
                    hold_data = beat[7:0];
                    in_frame  = !beat[9];
                end
            end else begin
                check("idle_last_err", 32'({m_last, m_err}), 32'd0);
                check("idle_hold_data", 32'(m_data), 32'(hold_data));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(negedge clock);
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic fill_payload(input int n, input int mul, input int add);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'((i * mul + add) & 8'hFF));
    endtask

    // Standard Ethernet FCS: reflected CRC-32, complemented, sent LSB byte first.
    task automatic add_fcs(input bit flip_bit0);
        logic [31:0] crc;
        logic [31:0] fcs;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < frm.size(); i++) begin
            crc = crc ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                if (crc[0]) crc = (crc >> 1) ^ 32'hEDB8_8320;
                else        crc = crc >> 1;
            end
        end
        fcs = ~crc;
        if (flip_bit0) fcs[0] = ~fcs[0];
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    // Sends preamble + frm + one idle cycle; queues the N-4 expected beats.
    task automatic send_frame(input int er_idx, input bit exp_err);
        int n;
        n = frm.size();
        for (int i = 0; i < n - 4; i++) begin
            exp_q.push_back({(i == n - 5), (i == n - 5) && exp_err, frm[i]});
        end
        if (exp_err) exp_bad++; else exp_good++;
        preamble();
        for (int i = 0; i < n; i++) drive(frm[i], 1'b1, (i == er_idx));
        idle(1);
    endtask

    task automatic settle_and_check(input string tag);
        idle(3);
        @(posedge clock);
        #1;
        check({tag, "_good_count"}, 32'(good_count), 32'(exp_good));
        check({tag, "_bad_count"},  32'(bad_count),  32'(exp_bad));
        check({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst_m_valid",    32'(m_valid),    32'd0);
        check("rst_m_last",     32'(m_last),     32'd0);
        check("rst_m_err",      32'(m_err),      32'd0);
        check("rst_m_data",     32'(m_data),     32'd0);
        check("rst_good_count", 32'(good_count), 32'd0);
        check("rst_bad_count",  32'(bad_count),  32'd0);
        check("rst_state",      32'(dbg_state),  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // 1. Good minimum frame: 60 payload bytes + FCS = 64
        fill_payload(60, 1, 0);
        add_fcs(1'b0);
        send_frame(-1, 1'b0);
        settle_and_check("good_min");

        // 2. Same frame with FCS bit 0 flipped
        fill_payload(60, 1, 0);
        add_fcs(1'b1);
        send_frame(-1, 1'b1);
        settle_and_check("bad_fcs");

        // 3. Good 64-byte frame with rx_er on payload byte 10
        fill_payload(60, 5, 3);
        add_fcs(1'b0);
        send_frame(10, 1'b1);
        settle_and_check("rx_er");

        // 4. Broken preamble: 0x55 0x55 0x12 then 30 bytes, must be dropped
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h12, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        check("drop_state", 32'(dbg_state), 32'd3);
        for (int i = 0; i < 30; i++) begin
            drive((i % 4 == 0) ? 8'hD5 : 8'((i * 7) & 8'hFF), 1'b1, 1'b0);
        end
        idle(1);
        settle_and_check("bad_preamble");

        // 5. Runt: 0x55 0xD5 then 3 bytes
        exp_q.push_back({1'b1, 1'b1, 8'h00});
        exp_bad++;
        drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        drive(8'hA1, 1'b1, 1'b0);
        drive(8'hB2, 1'b1, 1'b0);
        drive(8'hC3, 1'b1, 1'b0);
        idle(1);
        settle_and_check("runt");

        // 6. Two good frames separated by a single idle cycle
        fill_payload(60, 3, 1);
        add_fcs(1'b0);
        send_frame(-1, 1'b0);
        fill_payload(70, 11, 7);
        add_fcs(1'b0);
        send_frame(-1, 1'b0);
        settle_and_check("back_to_back");

        // 7. Reset at payload byte 20, dv held to frame end, then a good frame
        fill_payload(60, 1, 0);
        add_fcs(1'b0);
        for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, 1'b0, frm[i]});
        preamble();
        for (int i = 0; i < 20; i++) drive(frm[i], 1'b1, 1'b0);
        drive(frm[20], 1'b1, 1'b0);
        #1 reset_n = 1'b0;
        exp_good = 16'd0;
        exp_bad  = 16'd0;
        drive(frm[21], 1'b1, 1'b0);
        #1 reset_n = 1'b1;
        for (int i = 22; i < frm.size(); i++) drive(frm[i], 1'b1, 1'b0);
        idle(1);
        settle_and_check("reset_abandon");
        fill_payload(60, 9, 2);
        add_fcs(1'b0);
        send_frame(-1, 1'b0);
        settle_and_check("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
